// File: rtl/vga_code_ctrl.sv
// vga_code_ctrl: arbitrates two code requesters into a pending buffer and commits it at frame start (optional blink via VGA_CTRL_BLINK_EN)
module vga_code_ctrl #(
  parameter logic [23:0] RESET_CODE = 24'h000000,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        a_valid,
  input  logic [23:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [23:0] b_data,
  output logic        b_ready,
  input  logic        blink_en,
  output logic [23:0] code,
  output logic        pending,
  output logic        commit
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state;
  logic vsync_d, last, fs, a_win, b_win, commit_now;
  logic [23:0] pend_reg, code_reg, code_next;
  assign fs = vsync_d & ~vsync;
  assign a_win = ~rst & (state == IDLE) & a_valid & (~b_valid | last);
  assign b_win = ~rst & (state == IDLE) & b_valid & (~a_valid | ~last);
  assign a_ready = a_win;
  assign b_ready = b_win;
  assign pending = (state == PEND);
  assign commit_now = (state == PEND) & fs;
  assign code_next = commit_now ? pend_reg : code_reg;
  // vsync delay for falling-edge (frame start) detection
  always_ff @(posedge clk or posedge rst)
    if (rst) vsync_d <= 1'b1;
    else vsync_d <= vsync;
  // accept one code while idle, hold it until the next frame start; last=1 means B won last
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      pend_reg <= '0;
      code_reg <= RESET_CODE;
      commit <= 1'b0;
    end else begin
      commit <= commit_now;
      code_reg <= code_next;
      if (a_win | b_win) begin
        pend_reg <= a_win ? a_data : b_data;
        last <= b_win;
        state <= PEND;
      end else if (commit_now) state <= IDLE;
    end
`ifdef VGA_CTRL_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  logic [7:0] cnt;
  logic blank, wrap, blank_next;
  assign wrap = fs & (cnt == BLINK_LAST);
  assign blank_next = blink_en & (wrap ? ~blank : blank);
  // frame counter toggling blank; output register follows next-state so commit timing is unchanged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      blank <= 1'b0;
      code <= RESET_CODE;
    end else begin
      cnt <= ~blink_en ? 8'd0 : fs ? (wrap ? 8'd0 : cnt + 8'd1) : cnt;
      blank <= blank_next;
      code <= blank_next ? 24'h0 : code_next;
    end
`else
  logic unused_blink;
  assign unused_blink = blink_en & (BLINK_FRAMES > 0);
  assign code = code_reg;
`endif
endmodule
